// File: rtl/add_pipe_pkg.sv
// Shared constants and the packed result type for the adder issue/collect stage.
package add_pipe_pkg;

    localparam int ADD_W     = 8;
    localparam int ADD_LAT   = 5;
    localparam int ADD_DEPTH = 8;

    typedef struct packed {
        logic             cout;
        logic [ADD_W-1:0] sum;
    } add_res_t;

endpackage

// File: rtl/add_result_fifo.sv
// First-word-fall-through result FIFO; head reads as zero while empty.
module add_result_fifo
    import add_pipe_pkg::*;
#(
    parameter int DEPTH = ADD_DEPTH
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     wr_en,
    input  add_res_t wr_data,
    input  logic     rd_en,
    output add_res_t rd_data,
    output logic     empty,
    output logic     full
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    add_res_t        r_mem [DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            w_do_wr;
    logic            w_do_rd;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
        return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign empty   = (r_count == '0);
    assign full    = (r_count == CW'(DEPTH));
    assign w_do_rd = rd_en & ~empty;
    // A read in the same cycle frees the slot, so full-with-read may still write.
    assign w_do_wr = wr_en & (~full | w_do_rd);
    assign rd_data = empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_do_wr) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_wr) r_wr_ptr <= next_ptr(r_wr_ptr);
            if (w_do_rd) r_rd_ptr <= next_ptr(r_rd_ptr);
            case ({w_do_wr, w_do_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/add_pipe_collector.sv
// Issue/collect wrapper around an unstallable fixed-latency adder, with credit admission.
// ADD_COLLECT_CARRY_CNT_EN adds a saturating count of carry-out results on carry_cnt.
module add_pipe_collector
    import add_pipe_pkg::*;
#(
    parameter int LAT   = ADD_LAT,
    parameter int DEPTH = ADD_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ADD_W-1:0] in_a,
    input  logic [ADD_W-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [ADD_W-1:0] add_ina,
    output logic [ADD_W-1:0] add_inb,
    output logic             add_cin,
    input  logic [ADD_W-1:0] add_sum,
    input  logic             add_cout,
    output logic [ADD_W-1:0] out_sum,
    output logic             out_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
`ifdef ADD_COLLECT_CARRY_CNT_EN
   ,output logic [7:0]       carry_cnt
`endif
);

    localparam int OW = $clog2(DEPTH + 1);

    logic [LAT-1:0] r_vld_line;
    logic [OW-1:0]  r_occ;
    logic           w_in_fire;
    logic           w_out_fire;
    logic           w_wr_en;
    logic           w_fifo_empty;
    logic           w_fifo_full;
    add_res_t       w_wr_data;
    add_res_t       w_rd_data;

    // Both ports use valid/ready: a transfer happens in a cycle where both are high.
    // r_occ counts in-flight plus buffered results, so a write never meets a full FIFO.
    assign in_ready   = ~rst & (r_occ < OW'(DEPTH));
    assign w_in_fire  = in_valid & in_ready;
    assign out_valid  = ~w_fifo_empty;
    assign w_out_fire = out_valid & out_ready;
    assign busy       = (r_occ != '0);

    assign add_ina = in_a;
    assign add_inb = in_b;
    assign add_cin = in_cin;

    assign w_wr_en   = r_vld_line[LAT-1] & ~rst;
    assign w_wr_data = '{cout: add_cout, sum: add_sum};
    assign out_sum   = w_rd_data.sum;
    assign out_cout  = w_rd_data.cout;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_line <= '0;
            r_occ      <= '0;
        end else begin
            r_vld_line <= (r_vld_line << 1) | LAT'(w_in_fire);
            case ({w_in_fire, w_out_fire})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(w_wr_en && w_fifo_full && !w_out_fire));
        end
    end

    add_result_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (w_wr_en),
        .wr_data (w_wr_data),
        .rd_en   (w_out_fire),
        .rd_data (w_rd_data),
        .empty   (w_fifo_empty),
        .full    (w_fifo_full)
    );

`ifdef ADD_COLLECT_CARRY_CNT_EN
    logic [7:0] r_carry_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_carry_cnt <= '0;
        end else if (w_wr_en && add_cout && (r_carry_cnt != 8'hFF)) begin
            r_carry_cnt <= r_carry_cnt + 1'b1;
        end
    end

    assign carry_cnt = r_carry_cnt;
`endif

endmodule

// File: tb/tb_add_pipe_collector.sv
// Bench for add_pipe_collector: DEPTH=8 and DEPTH=4 instances, each fed by a 5-stage adder model.
module tb_add_pipe_collector;

    logic clk = 0;
    logic rst = 1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    // DEPTH=8 instance
    logic [7:0] a_in_a = 0, a_in_b = 0, a_ina, a_inb, a_add_sum, a_out_sum;
    logic       a_in_cin = 0, a_in_valid = 0, a_in_ready, a_cin, a_add_cout;
    logic       a_out_cout, a_out_valid, a_out_ready = 0, a_busy;
`ifdef ADD_COLLECT_CARRY_CNT_EN
    logic [7:0] a_carry_cnt, b_carry_cnt;
`endif
    // DEPTH=4 instance
    logic [7:0] b_in_a = 0, b_in_b = 0, b_ina, b_inb, b_add_sum, b_out_sum;
    logic       b_in_cin = 0, b_in_valid = 0, b_in_ready, b_cin, b_add_cout;
    logic       b_out_cout, b_out_valid, b_out_ready = 0, b_busy;

    logic [8:0] pa [5];
    logic [8:0] pb [5];
    logic [8:0] exp_q[$];

    always_ff @(posedge clk) begin
        pa[0] <= {1'b0, a_ina} + {1'b0, a_inb} + {8'b0, a_cin};
        pb[0] <= {1'b0, b_ina} + {1'b0, b_inb} + {8'b0, b_cin};
        for (int i = 1; i < 5; i++) begin
            pa[i] <= pa[i-1];
            pb[i] <= pb[i-1];
        end
    end
    assign a_add_sum  = pa[4][7:0];
    assign a_add_cout = pa[4][8];
    assign b_add_sum  = pb[4][7:0];
    assign b_add_cout = pb[4][8];

    add_pipe_collector #(.LAT(5), .DEPTH(8)) dut_a (
        .clk(clk), .rst(rst), .in_a(a_in_a), .in_b(a_in_b), .in_cin(a_in_cin),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .add_ina(a_ina), .add_inb(a_inb),
        .add_cin(a_cin), .add_sum(a_add_sum), .add_cout(a_add_cout), .out_sum(a_out_sum),
        .out_cout(a_out_cout), .out_valid(a_out_valid), .out_ready(a_out_ready), .busy(a_busy)
`ifdef ADD_COLLECT_CARRY_CNT_EN
       ,.carry_cnt(a_carry_cnt)
`endif
    );

    add_pipe_collector #(.LAT(5), .DEPTH(4)) dut_b (
        .clk(clk), .rst(rst), .in_a(b_in_a), .in_b(b_in_b), .in_cin(b_in_cin),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .add_ina(b_ina), .add_inb(b_inb),
        .add_cin(b_cin), .add_sum(b_add_sum), .add_cout(b_add_cout), .out_sum(b_out_sum),
        .out_cout(b_out_cout), .out_valid(b_out_valid), .out_ready(b_out_ready), .busy(b_busy)
`ifdef ADD_COLLECT_CARRY_CNT_EN
       ,.carry_cnt(b_carry_cnt)
`endif
    );

    // Overflow monitor: a FIFO write at full without a simultaneous read must never happen.
    always @(negedge clk) begin
        if (!rst && dut_a.w_wr_en && dut_a.w_fifo_full && !dut_a.w_out_fire) begin
            errors++;
            $display("FAIL overflow_a: write into full FIFO at %0t", $time);
        end
        if (!rst && dut_b.w_wr_en && dut_b.w_fifo_full && !dut_b.w_out_fire) begin
            errors++;
            $display("FAIL overflow_b: write into full FIFO at %0t", $time);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1;
        repeat (3) tick;
        rst = 0;
        #1;
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b expected 0", a_out_valid); end
        checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b expected 1", a_in_ready); end
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", a_busy); end
        checks++; if ({a_out_cout, a_out_sum} !== 9'h000) begin errors++; $display("FAIL rst_out_data: got %h expected 000", {a_out_cout, a_out_sum}); end
        checks++; if (b_in_ready !== 1'b1) begin errors++; $display("FAIL rst_b_in_ready: got %b expected 1", b_in_ready); end
`ifdef ADD_COLLECT_CARRY_CNT_EN
        checks++; if (a_carry_cnt !== 8'd0) begin errors++; $display("FAIL rst_carry_cnt: got %0d expected 0", a_carry_cnt); end
`endif
    endtask

    task automatic test_single;
        a_out_ready = 0;
        a_in_a = 8'h7F; a_in_b = 8'h01; a_in_cin = 0; a_in_valid = 1;
        checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL single_in_ready: got %b expected 1", a_in_ready); end
        tick;
        a_in_valid = 0;
        for (int c = 1; c <= 6; c++) begin
            checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL single_busy c%0d: got %b expected 1", c, a_busy); end
            if (c < 6) begin
                checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL single_early c%0d: got %b expected 0", c, a_out_valid); end
                tick;
            end
        end
        checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", a_out_valid); end
        checks++; if ({a_out_cout, a_out_sum} !== 9'h080) begin errors++; $display("FAIL single_data: got %h expected 080", {a_out_cout, a_out_sum}); end
        tick;
        checks++; if ({a_out_cout, a_out_sum} !== 9'h080) begin errors++; $display("FAIL single_stable: got %h expected 080", {a_out_cout, a_out_sum}); end
        a_out_ready = 1;
        tick;
        a_out_ready = 0;
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL single_drained: got %b expected 0", a_out_valid); end
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL single_idle_busy: got %b expected 0", a_busy); end
    endtask

    task automatic test_back_to_back;
        a_out_ready = 1;
        a_in_a = 8'hFF; a_in_b = 8'h01; a_in_cin = 0; a_in_valid = 1;
        tick;
        a_in_a = 8'hAA; a_in_b = 8'h55; a_in_cin = 1;
        tick;
        a_in_valid = 0;
        repeat (4) tick;
        checks++; if ({a_out_valid, a_out_cout, a_out_sum} !== 10'h300) begin errors++; $display("FAIL b2b_first: got %h expected 300", {a_out_valid, a_out_cout, a_out_sum}); end
        tick;
        checks++; if ({a_out_valid, a_out_cout, a_out_sum} !== 10'h300) begin errors++; $display("FAIL b2b_second: got %h expected 300", {a_out_valid, a_out_cout, a_out_sum}); end
        tick;
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty: got %b expected 0", a_out_valid); end
        a_out_ready = 0;
    endtask

    task automatic test_depth4_backpressure;
        int fires = 0;
        int got = 0;
        logic [8:0] e;
        exp_q.delete();
        b_out_ready = 0;
        b_in_valid  = 1;
        for (int k = 0; k < 12; k++) begin
            b_in_a   = 8'hF0 + 8'(fires * 4);
            b_in_b   = 8'h10;
            b_in_cin = fires[0];
            if (b_in_ready) begin
                exp_q.push_back({1'b0, b_in_a} + {1'b0, b_in_b} + {8'b0, b_in_cin});
                fires++;
            end
            tick;
        end
        b_in_valid = 0;
        checks++; if (fires != 4) begin errors++; $display("FAIL d4_fires: got %0d expected 4", fires); end
        checks++; if (b_in_ready !== 1'b0) begin errors++; $display("FAIL d4_in_ready: got %b expected 0", b_in_ready); end
        b_out_ready = 1;
        for (int k = 0; k < 30 && got < 4; k++) begin
            if (b_out_valid) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h1FF;
                got++;
                checks++; if ({b_out_cout, b_out_sum} !== e) begin errors++; $display("FAIL d4_data%0d: got %h expected %h", got, {b_out_cout, b_out_sum}, e); end
            end
            tick;
        end
        checks++; if (got != 4) begin errors++; $display("FAIL d4_drain_count: got %0d expected 4", got); end
        checks++; if (b_busy !== 1'b0) begin errors++; $display("FAIL d4_idle: got %b expected 0", b_busy); end
        b_out_ready = 0;
    endtask

    task automatic test_random;
        int sent = 0;
        int occ_m = 0;
        int cyc = 0;
        logic [8:0] e;
        exp_q.delete();
        while ((sent < 100 || exp_q.size() > 0) && cyc < 3000) begin
            a_out_ready = 1'($urandom_range(0, 1));
            a_in_valid  = (sent < 100) && ($urandom_range(0, 3) != 0);
            a_in_a      = 8'($urandom_range(0, 255));
            a_in_b      = 8'($urandom_range(0, 255));
            a_in_cin    = 1'($urandom_range(0, 1));
            checks++; if (a_in_ready !== (occ_m < 8)) begin errors++; $display("FAIL rand_in_ready: got %b expected %b occ %0d", a_in_ready, occ_m < 8, occ_m); end
            if (a_in_valid && a_in_ready) begin
                exp_q.push_back({1'b0, a_in_a} + {1'b0, a_in_b} + {8'b0, a_in_cin});
                sent++;
                occ_m++;
            end
            if (a_out_valid && a_out_ready) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h1FF;
                occ_m--;
                checks++; if ({a_out_cout, a_out_sum} !== e) begin errors++; $display("FAIL rand_data: got %h expected %h", {a_out_cout, a_out_sum}, e); end
            end
            tick;
            cyc++;
        end
        a_in_valid = 0;
        a_out_ready = 0;
        checks++; if (sent != 100 || exp_q.size() != 0) begin errors++; $display("FAIL rand_timeout: sent %0d pending %0d expected 100 and 0", sent, exp_q.size()); end
    endtask

    task automatic test_reset_mid;
        a_out_ready = 0;
        a_in_valid  = 1;
        for (int k = 0; k < 5; k++) begin
            a_in_a = 8'(8'h11 * k); a_in_b = 8'h22; a_in_cin = 1;
            tick;
        end
        a_in_valid = 0;
        repeat (2) tick;
        checks++; if ({a_busy, a_out_valid} !== 2'b11) begin errors++; $display("FAIL mid_pre: got %b expected 11", {a_busy, a_out_valid}); end
        rst = 1;
        #1;
        checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL mid_in_ready_rst: got %b expected 0", a_in_ready); end
        tick;
        rst = 0;
        #1;
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid: got %b expected 0", a_out_valid); end
        checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready: got %b expected 1", a_in_ready); end
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b expected 0", a_busy); end
        checks++; if (dut_a.r_occ !== 4'd0) begin errors++; $display("FAIL mid_occ: got %0d expected 0", dut_a.r_occ); end
        a_out_ready = 1;
        for (int k = 0; k < 12; k++) begin
            tick;
            checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL mid_stale c%0d: got %b expected 0", k, a_out_valid); end
        end
        a_out_ready = 0;
    endtask

`ifdef ADD_COLLECT_CARRY_CNT_EN
    task automatic test_carry_cnt;
        int sent = 0;
        a_out_ready = 1;
        a_in_a = 8'h80; a_in_b = 8'h80; a_in_cin = 0; a_in_valid = 1;
        for (int k = 0; k < 1000 && sent < 300; k++) begin
            if (a_in_ready) sent++;
            tick;
        end
        a_in_valid = 0;
        repeat (20) tick;
        checks++; if (a_carry_cnt !== 8'd255) begin errors++; $display("FAIL carry_cnt_sat: got %0d expected 255", a_carry_cnt); end
        a_out_ready = 0;
    endtask
`endif

    initial begin
        test_reset;
        test_single;
        test_back_to_back;
        test_depth4_backpressure;
        test_random;
        test_reset_mid;
`ifdef ADD_COLLECT_CARRY_CNT_EN
        test_carry_cnt;
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
